mem_port_ctrl: RTL and testbench
================================

// Module: mem_port_ctrl
// PURPOSE
//  Single-port memory controller between the multicycle cpu and dbg_mem.
//  Arbitrates instruction fetch, data load and data store requests onto one memory
//  port, and returns read data with a registered valid pulse.
//  Replaces the combinational pc_en/l_addr mux; adds byte-enable stores, multi-cycle
//  memory latency and misalignment errors.
// PARAMETERS
//  W        32  data/address width (bits)
//  LATENCY  1   memory read latency in cycles; legal range 1..15 (4-bit counter)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  if_req     in   1   fetch request; held high until if_gnt
//  if_addr    in   W   fetch byte address
//  if_gnt     out  1   fetch accepted this cycle (combinational)
//  if_rvalid  out  1   one-cycle pulse: if_rdata valid
//  if_rdata   out  W   fetched word
//  ld_req     in   1   load request; held high until ld_gnt
//  ld_addr    in   W   load byte address
//  ld_gnt     out  1   load accepted this cycle (combinational)
//  ld_rvalid  out  1   one-cycle pulse: ld_rdata valid
//  ld_rdata   out  W   loaded word
//  st_req     in   1   store request; held high until st_gnt
//  st_addr    in   W   store byte address; bits [1:0] ignored
//  st_data    in   W   store data, lane-aligned
//  st_be      in   W/8 byte enables
//  st_gnt     out  1   store accepted this cycle (combinational)
//  st_done    out  1   one-cycle pulse: store committed
//  err        out  1   one-cycle pulse alongside rvalid: misaligned fetch/load
//  busy       out  1   state != IDLE
//  mem_en     out  1   memory access strobe, one cycle per access
//  mem_we     out  1   write qualifier for mem_en
//  mem_addr   out  W   word address ({addr[W-1:2],2'b00}), held for whole access
//  mem_wdata  out  W   write data
//  mem_be     out  W/8 write byte enables
//  mem_rdata  in   W   memory read data
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0 (rdata regs 0); any in-flight access is
//    dropped; no rvalid/st_done/err is emitted for it.
//  - FSM states: IDLE, ACCESS, ERR.
//  - Grant is issued only in IDLE. Priority: store > load > fetch.
//    Exactly one gnt may be high. Losing requesters see gnt=0 and must hold req.
//  - On grant, addr, data, be and kind are latched. Requester inputs are ignored
//    after that.
//  - Fetch/load with addr[1:0]!=0: IDLE->ERR. No memory access.
//    The ERR cycle drives the kind's rvalid=1, err=1, rdata=0; then returns to IDLE.
//  - Otherwise IDLE->ACCESS:
//    - mem_en=1 only in the first ACCESS cycle; mem_we=1 there for stores.
//    - mem_addr/wdata/be are stable for all ACCESS cycles.
//    - ACCESS lasts LATENCY cycles.
//    - Loads/fetches sample mem_rdata only at the end of the last ACCESS cycle.
//  - ACCESS->IDLE: in the first IDLE cycle, the matching rvalid (or st_done) is
//    high for exactly 1 cycle. rdata holds its value until the next response of
//    the same kind.
//  - Latency for a word access: gnt in cycle 0, mem_en in cycle 1, rvalid in cycle
//    LATENCY+1.
//  - A new grant may be issued in the same IDLE cycle as the response pulse.
//    Throughput is one access per LATENCY+1 cycles.
//  - Stores: byte lane i is written iff st_be[i]. st_be=0 still performs a mem_en
//    cycle and pulses st_done.
//  - Fetch can be starved by continuous stores/loads; the cpu never requests
//    concurrently in steady state.
//  - rst during ACCESS or ERR: next cycle IDLE with all outputs 0. The memory write
//    is suppressed unless mem_en was already issued.
// TESTING
//  1 LATENCY=1, mem[0x40]=0x24080005, if_req addr 0x40 @c0 -> if_gnt c0, mem_en c1,
//    if_rvalid c2, if_rdata=0x24080005.
//  2 st(0x100,0xDEADBEEF,be=1111)+ld(0x100)+if(0x0) all @c0 -> st_gnt c0, ld_gnt c2,
//    if_gnt c4. ld_rdata=0xDEADBEEF.
//  3 mem[0x80]=0x11223344, st be=0010 data 0x0000AB00 -> load 0x80 returns
//    0x1122AB44.
//  4 ld_req addr 0x102 -> ld_gnt c0, no mem_en, c1 ld_rvalid=1 err=1 ld_rdata=0.
//  5 LATENCY=3, mem_rdata garbage until c3 -> ld_rvalid at c4 with the c3 value only.
//  6 rst in 2nd ACCESS cycle (LATENCY=3) -> next cycle all outputs 0, no rvalid.
//    A new if_req is granted on the first cycle after rst drops.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl
//   Single-port memory controller between the multicycle cpu and dbg_mem.
//   Arbitrates fetch, load and store requests (store > load > fetch) onto one
//   memory port. Loads and fetches return data with a registered one-cycle
//   valid pulse. Stores pulse st_done. A misaligned fetch or load never
//   reaches memory and is answered with err.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request      -> if_gnt, if_rvalid, if_rdata
//   ld_req/ld_addr           load request       -> ld_gnt, ld_rvalid, ld_rdata
//   st_req/st_addr/st_data/st_be  store request -> st_gnt, st_done
//   err                      pulses with rvalid for a misaligned fetch/load
//   busy                     controller not idle
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be/mem_rdata  memory port
module mem_port_ctrl #(
    parameter int W       = 32,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  logic [W-1:0]   if_addr,
    output logic           if_gnt,
    output logic           if_rvalid,
    output logic [W-1:0]   if_rdata,
    input  logic           ld_req,
    input  logic [W-1:0]   ld_addr,
    output logic           ld_gnt,
    output logic           ld_rvalid,
    output logic [W-1:0]   ld_rdata,
    input  logic           st_req,
    input  logic [W-1:0]   st_addr,
    input  logic [W-1:0]   st_data,
    input  logic [W/8-1:0] st_be,
    output logic           st_gnt,
    output logic           st_done,
    output logic           err,
    output logic           busy,
    output logic           mem_en,
    output logic           mem_we,
    output logic [W-1:0]   mem_addr,
    output logic [W-1:0]   mem_wdata,
    output logic [W/8-1:0] mem_be,
    input  logic [W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;
    typedef enum logic [1:0] {K_IF, K_LD, K_ST} kind_t;

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    state_t         state, state_nx;
    kind_t          kind_q, kind_nx;
    logic [3:0]     cnt;
    logic [W-1:0]   addr_q, wdata_q;
    logic [W/8-1:0] be_q;
    logic [W-1:0]   req_addr;
    logic           grant, misaligned, last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        kind_nx    = kind_q;
        if_gnt     = 1'b0;
        ld_gnt     = 1'b0;
        st_gnt     = 1'b0;
        req_addr   = '0;
        grant      = 1'b0;
        misaligned = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        last       = (cnt == LAST_CNT);
        case (state)
            IDLE: begin
                // Grants are suppressed during reset so a request is never
                // acknowledged without its latch taking effect.
                if (!rst) begin
                    if (st_req) begin
                        st_gnt   = 1'b1;
                        kind_nx  = K_ST;
                        req_addr = st_addr;
                    end else if (ld_req) begin
                        ld_gnt   = 1'b1;
                        kind_nx  = K_LD;
                        req_addr = ld_addr;
                    end else if (if_req) begin
                        if_gnt   = 1'b1;
                        kind_nx  = K_IF;
                        req_addr = if_addr;
                    end
                    grant      = st_req | ld_req | if_req;
                    misaligned = (kind_nx != K_ST) && (|req_addr[1:0]);
                    if (grant) state_nx = misaligned ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                // A reset arriving in the strobe cycle cancels the write.
                mem_en = (cnt == '0) && !rst;
                mem_we = mem_en && (kind_q == K_ST);
                if (last) state_nx = IDLE;
            end
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign mem_addr  = (state == ACCESS) ? addr_q  : '0;
    assign mem_wdata = (state == ACCESS) ? wdata_q : '0;
    assign mem_be    = (state == ACCESS) ? be_q    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q    <= K_IF;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cnt       <= '0;
            if_rvalid <= 1'b0;
            ld_rvalid <= 1'b0;
            st_done   <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            ld_rdata  <= '0;
        end else begin
            kind_q    <= kind_nx;
            if_rvalid <= 1'b0;
            ld_rvalid <= 1'b0;
            st_done   <= 1'b0;
            err       <= 1'b0;
            if (grant) begin
                addr_q  <= {req_addr[W-1:2], 2'b00};
                wdata_q <= st_gnt ? st_data : '0;
                be_q    <= st_gnt ? st_be : '0;
                cnt     <= '0;
                // The error response is registered so it lands in the ERR cycle.
                if (misaligned) begin
                    err <= 1'b1;
                    if (ld_gnt) begin
                        ld_rvalid <= 1'b1;
                        ld_rdata  <= '0;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= '0;
                    end
                end
            end
            if (state == ACCESS) begin
                cnt <= cnt + 4'd1;
                if (last) begin
                    case (kind_q)
                        K_IF: begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                        K_LD: begin
                            ld_rvalid <= 1'b1;
                            ld_rdata  <= mem_rdata;
                        end
                        default: st_done <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl
//   Bench for mem_port_ctrl with two instances (LATENCY 1 and 3). Only the
//   selected instance runs; the other is held in reset. Each instance has its
//   own memory model whose read data is only correct in the last cycle of
//   the access window.
`timescale 1ns/1ps
module tb_mem_port_ctrl;
    localparam int W  = 32;
    localparam int NB = W/8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, sel;
    logic          if_req, ld_req, st_req;
    logic [W-1:0]  if_addr, ld_addr, st_addr, st_data;
    logic [NB-1:0] st_be;
    logic          bd_we;
    logic [7:0]    bd_idx;
    logic [W-1:0]  bd_data;

    logic [1:0] if_gnt_v, if_rvalid_v, ld_gnt_v, ld_rvalid_v, st_gnt_v, st_done_v;
    logic [1:0] err_v, busy_v, mem_en_v, mem_we_v;
    logic [1:0][W-1:0]  if_rdata_v, ld_rdata_v, mem_addr_v, mem_wdata_v;
    logic [1:0][NB-1:0] mem_be_v;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [W-1:0] mem [256];
        logic [W-1:0] mem_rdata;
        logic         dut_rst;
        int           age_q = 0;
        int           age;
        assign dut_rst   = rst || (sel != 1'(g));
        assign age       = mem_en_v[g] ? 0 : age_q;
        assign mem_rdata = (age == LAT - 1) ? mem[mem_addr_v[g][9:2]] : ~mem[mem_addr_v[g][9:2]];
        always @(posedge clk) begin
            age_q <= mem_en_v[g] ? 1 : age_q + 1;
            if (bd_we) mem[bd_idx] <= bd_data;
            else if (mem_en_v[g] && mem_we_v[g])
                for (int b = 0; b < NB; b++)
                    if (mem_be_v[g][b]) mem[mem_addr_v[g][9:2]][8*b +: 8] <= mem_wdata_v[g][8*b +: 8];
        end
        mem_port_ctrl #(.W(W), .LATENCY(LAT)) u_dut (
            .clk(clk), .rst(dut_rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_v[g]),
            .if_rvalid(if_rvalid_v[g]), .if_rdata(if_rdata_v[g]),
            .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt_v[g]),
            .ld_rvalid(ld_rvalid_v[g]), .ld_rdata(ld_rdata_v[g]),
            .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
            .st_gnt(st_gnt_v[g]), .st_done(st_done_v[g]),
            .err(err_v[g]), .busy(busy_v[g]),
            .mem_en(mem_en_v[g]), .mem_we(mem_we_v[g]), .mem_addr(mem_addr_v[g]),
            .mem_wdata(mem_wdata_v[g]), .mem_be(mem_be_v[g]), .mem_rdata(mem_rdata)
        );
    end

    logic if_gnt, if_rvalid, ld_gnt, ld_rvalid, st_gnt, st_done, err, busy, mem_en, mem_we;
    logic [W-1:0]  if_rdata, ld_rdata, mem_addr, mem_wdata;
    logic [NB-1:0] mem_be;
    assign if_gnt    = if_gnt_v[sel];
    assign if_rvalid = if_rvalid_v[sel];
    assign if_rdata  = if_rdata_v[sel];
    assign ld_gnt    = ld_gnt_v[sel];
    assign ld_rvalid = ld_rvalid_v[sel];
    assign ld_rdata  = ld_rdata_v[sel];
    assign st_gnt    = st_gnt_v[sel];
    assign st_done   = st_done_v[sel];
    assign err       = err_v[sel];
    assign busy      = busy_v[sel];
    assign mem_en    = mem_en_v[sel];
    assign mem_we    = mem_we_v[sel];
    assign mem_addr  = mem_addr_v[sel];
    assign mem_wdata = mem_wdata_v[sel];
    assign mem_be    = mem_be_v[sel];

    int checks = 0;
    int passes = 0;
    int lat;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL lat=%0d %s: got %h expected %h", lat, name, act, exp);
    endfunction

    // Reference state: memory image and per-round expectations/observations.
    // Kind index: 0 fetch, 1 load, 2 store.
    logic [W-1:0]  ref_mem [256];
    logic [2:0]    r_mask;
    logic [W-1:0]  r_addr [3];
    logic [W-1:0]  r_sd;
    logic [NB-1:0] r_sb;
    int            exp_g [3], exp_r [3], obs_g [3], obs_r [3], obs_n [3];
    logic [W-1:0]  exp_d [3], obs_d [3];
    logic          exp_e [3], obs_e [3];
    int            obs_en;

    typedef struct {
        logic [2:0]    mask;
        logic [W-1:0]  st_a, st_d;
        logic [NB-1:0] st_b;
        logic [W-1:0]  ld_a, if_a;
        logic [W-1:0]  exp_ld;
        logic          exp_ld_err;
        logic [W-1:0]  exp_if;
        logic          exp_if_err;
    } vec_t;
    vec_t tbl [12];

    // Requests are served strictly in priority order; each aligned access
    // occupies LATENCY+1 cycles, each misaligned one occupies 2.
    task automatic model_round();
        int t = 0;
        for (int k = 2; k >= 0; k--) begin
            exp_g[k] = -1; exp_r[k] = -1; exp_d[k] = '0; exp_e[k] = 1'b0;
            if (r_mask[k]) begin
                logic bad;
                int   idx;
                bad = (k != 2) && (r_addr[k][1:0] != 2'b00);
                idx = int'(r_addr[k][9:2]);
                exp_g[k] = t;
                if (bad) begin
                    exp_r[k] = t + 1;
                    exp_e[k] = 1'b1;
                    t += 2;
                end else begin
                    exp_r[k] = t + lat + 1;
                    if (k == 2) begin
                        for (int b = 0; b < NB; b++)
                            if (r_sb[b]) ref_mem[idx][8*b +: 8] = r_sd[8*b +: 8];
                    end else begin
                        exp_d[k] = ref_mem[idx];
                    end
                    t += lat + 1;
                end
            end
        end
    endtask

    task automatic run_round();
        logic [2:0]   pend, gotr, gnts, rv;
        logic [W-1:0] cur_addr;
        logic         cur_bad, prev_gnt;
        int           c, cur_k;
        pend = r_mask; gotr = '0; cur_addr = '0; cur_bad = 1'b1; cur_k = 0; prev_gnt = 1'b0;
        obs_en = 0;
        for (int k = 0; k < 3; k++) begin
            obs_g[k] = -1; obs_r[k] = -1; obs_n[k] = 0; obs_d[k] = '0; obs_e[k] = 1'b0;
        end
        c = 0;
        while (gotr != r_mask && c < 80) begin
            @(posedge clk); #1;
            if_req  = pend[0];
            ld_req  = pend[1];
            st_req  = pend[2];
            // Idle lanes carry junk so only latched values may reach memory.
            if_addr = pend[0] ? r_addr[0] : $urandom;
            ld_addr = pend[1] ? r_addr[1] : $urandom;
            st_addr = pend[2] ? r_addr[2] : $urandom;
            st_data = pend[2] ? r_sd : $urandom;
            st_be   = pend[2] ? r_sb : NB'($urandom);
            @(negedge clk);
            if (prev_gnt) chk("busy_after_gnt", 32'(busy), 32'd1);
            gnts = {st_gnt, ld_gnt, if_gnt};
            prev_gnt = (gnts != 3'b000);
            if (gnts != 3'b000) chk("gnt_onehot", 32'($onehot(gnts)), 32'd1);
            rv = {st_done, ld_rvalid, if_rvalid};
            if (err && !(if_rvalid || ld_rvalid)) chk("err_without_rvalid", 32'(err), 32'd0);
            for (int k = 0; k < 3; k++) begin
                if (rv[k]) begin
                    obs_n[k]++;
                    if (obs_r[k] < 0) obs_r[k] = c;
                    obs_d[k] = (k == 0) ? if_rdata : (k == 1) ? ld_rdata : '0;
                    obs_e[k] = err;
                    gotr[k]  = 1'b1;
                end
            end
            if (busy && !cur_bad) chk("mem_addr", mem_addr, cur_addr);
            if (mem_en) begin
                obs_en++;
                chk("mem_en_cycle", 32'(c), 32'(obs_g[cur_k] + 1));
                chk("mem_we", 32'(mem_we), 32'(cur_k == 2));
                if (cur_k == 2) begin
                    chk("mem_wdata", mem_wdata, r_sd);
                    chk("mem_be", 32'(mem_be), 32'(r_sb));
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (gnts[k]) begin
                    obs_g[k] = c;
                    pend[k]  = 1'b0;
                    cur_k    = k;
                    cur_addr = {r_addr[k][W-1:2], 2'b00};
                    cur_bad  = (k != 2) && (r_addr[k][1:0] != 2'b00);
                end
            end
            c++;
        end
        if (gotr != r_mask) chk("round_timeout", 32'(gotr), 32'(r_mask));
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    endtask

    task automatic compare_round();
        int n_al = 0;
        for (int k = 0; k < 3; k++) begin
            if (r_mask[k]) begin
                chk($sformatf("k%0d_gnt_cycle", k), 32'(obs_g[k]), 32'(exp_g[k]));
                chk($sformatf("k%0d_resp_cycle", k), 32'(obs_r[k]), 32'(exp_r[k]));
                chk($sformatf("k%0d_pulses", k), 32'(obs_n[k]), 32'd1);
                chk($sformatf("k%0d_err", k), 32'(obs_e[k]), 32'(exp_e[k]));
                if (k < 2) chk($sformatf("k%0d_rdata", k), obs_d[k], exp_d[k]);
                if (!exp_e[k]) n_al++;
            end
        end
        chk("mem_en_count", 32'(obs_en), 32'(n_al));
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            bd_we   = 1'b1;
            bd_idx  = 8'(i);
            bd_data = 32'h1000_0000 + 32'(i) * 32'h101;
            ref_mem[i] = bd_data;
        end
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        chk("rst_st_gnt", 32'(st_gnt), 32'd0);
        chk("rst_rvalids", 32'({if_rvalid, ld_rvalid, st_done, err}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en_we", 32'({mem_en, mem_we}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ld_rdata", ld_rdata, 32'd0);
    endtask

    task automatic reset_mid_access();
        int rc;
        rc = (lat >= 2) ? 2 : 1;
        @(posedge clk); #1;
        ld_req = 1'b1; ld_addr = 32'h100;
        @(negedge clk);
        chk("rma_ld_gnt", 32'(ld_gnt), 32'd1);
        for (int c = 1; c <= rc; c++) begin
            @(posedge clk); #1;
            ld_req = 1'b0;
            rst    = (c == rc);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        @(negedge clk);
        chk("rma_if_gnt", 32'(if_gnt), 32'd1);
        chk("rma_pulses", 32'({if_rvalid, ld_rvalid, st_done, err}), 32'd0);
        chk("rma_busy", 32'(busy), 32'd0);
        chk("rma_mem_en", 32'(mem_en), 32'd0);
        chk("rma_mem_addr", mem_addr, 32'd0);
        chk("rma_ld_rdata", ld_rdata, 32'd0);
        chk("rma_if_rdata", if_rdata, 32'd0);
        for (int c = 1; c <= lat + 1; c++) begin
            @(posedge clk); #1;
            if_req = 1'b0;
            @(negedge clk);
            chk("rma_no_ld_rvalid", 32'(ld_rvalid), 32'd0);
            chk($sformatf("rma_if_rvalid_c%0d", c), 32'(if_rvalid), 32'(c == lat + 1));
        end
        chk("rma_if_rdata_after", if_rdata, ref_mem[16]);
    endtask

    task automatic run_phase(input int p);
        @(posedge clk); #1;
        sel = p[0];
        lat = (p == 0) ? 1 : 3;
        rst = 1'b1;
        if_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
        if_addr = 32'h40; ld_addr = 32'h80; st_addr = 32'h100;
        st_data = 32'hFFFF_FFFF; st_be = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        preload();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            r_mask = tbl[i].mask;
            r_addr[0] = tbl[i].if_a; r_addr[1] = tbl[i].ld_a; r_addr[2] = tbl[i].st_a;
            r_sd = tbl[i].st_d; r_sb = tbl[i].st_b;
            model_round();
            run_round();
            compare_round();
            if (r_mask[1]) begin
                chk($sformatf("tbl%0d_ld_rdata", i), obs_d[1], tbl[i].exp_ld);
                chk($sformatf("tbl%0d_ld_err", i), 32'(obs_e[1]), 32'(tbl[i].exp_ld_err));
            end
            if (r_mask[0]) begin
                chk($sformatf("tbl%0d_if_rdata", i), obs_d[0], tbl[i].exp_if);
                chk($sformatf("tbl%0d_if_err", i), 32'(obs_e[0]), 32'(tbl[i].exp_if_err));
            end
        end

        reset_mid_access();

        for (int i = 0; i < 120; i++) begin
            r_mask = 3'($urandom_range(1, 7));
            for (int k = 0; k < 3; k++) begin
                logic [1:0] lo;
                lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                if (k == 2) lo = 2'($urandom);
                r_addr[k] = {22'b0, 8'($urandom), lo};
            end
            r_sd = $urandom;
            r_sb = NB'($urandom);
            model_round();
            run_round();
            compare_round();
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sel = 1'b0; lat = 1;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; st_be = '0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;

        // mask bit 2 store, bit 1 load, bit 0 fetch; preload word i = 0x10000000 + i*0x101
        tbl[0]  = '{3'b100, 32'h40,  32'h24080005, 4'hF,    32'h0,   32'h0,   32'h0,        1'b0, 32'h0,        1'b0};
        tbl[1]  = '{3'b001, 32'h0,   32'h0,        4'h0,    32'h0,   32'h40,  32'h0,        1'b0, 32'h24080005, 1'b0};
        tbl[2]  = '{3'b111, 32'h100, 32'hDEADBEEF, 4'hF,    32'h100, 32'h0,   32'hDEADBEEF, 1'b0, 32'h10000000, 1'b0};
        tbl[3]  = '{3'b100, 32'h80,  32'h11223344, 4'hF,    32'h0,   32'h0,   32'h0,        1'b0, 32'h0,        1'b0};
        tbl[4]  = '{3'b100, 32'h80,  32'h0000AB00, 4'b0010, 32'h0,   32'h0,   32'h0,        1'b0, 32'h0,        1'b0};
        tbl[5]  = '{3'b010, 32'h0,   32'h0,        4'h0,    32'h80,  32'h0,   32'h1122AB44, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{3'b010, 32'h0,   32'h0,        4'h0,    32'h102, 32'h0,   32'h0,        1'b1, 32'h0,        1'b0};
        tbl[7]  = '{3'b001, 32'h0,   32'h0,        4'h0,    32'h0,   32'h81,  32'h0,        1'b0, 32'h0,        1'b1};
        tbl[8]  = '{3'b110, 32'h83,  32'h55000000, 4'b1000, 32'h80,  32'h0,   32'h5522AB44, 1'b0, 32'h0,        1'b0};
        tbl[9]  = '{3'b101, 32'h84,  32'hFFFFFFFF, 4'h0,    32'h0,   32'h84,  32'h0,        1'b0, 32'h10002121, 1'b0};
        tbl[10] = '{3'b011, 32'h0,   32'h0,        4'h0,    32'h3FC, 32'h3FE, 32'h1000FFFF, 1'b0, 32'h0,        1'b1};
        tbl[11] = '{3'b111, 32'h200, 32'hAABBCCDD, 4'b1001, 32'h200, 32'h203, 32'hAA0080DD, 1'b0, 32'h0,        1'b1};

        run_phase(0);
        run_phase(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
